// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate front-end.
// No logic; compile-time definitions only.
// No flow control.
package parking_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        OPEN,
        EMIT,
        DENY,
        WAIT_CLEAR
    } gate_state_t;

    localparam int HOURS_PER_DAY    = 24;
    localparam int MINUTES_PER_HOUR = 60;
    localparam int HM_W             = 6;

endpackage

// File: rtl/parking_gate_ctrl_if.sv
// Gate sensors, vacancy flags, event stream and time-of-day bundle.
// Pure wiring, no latency.
// No flow control; events are single-cycle pulses.
interface parking_gate_ctrl_if;
    import parking_pkg::*;

    logic            entry_req;
    logic            entry_is_uni;
    logic            entry_pass;
    logic            exit_req;
    logic            exit_is_uni;
    logic            exit_pass;
    logic            uni_is_vacated_space;
    logic            is_vacated_space;
    logic            car_entered;
    logic            is_uni_car_entered;
    logic            car_exited;
    logic            is_uni_car_exited;
    logic [HM_W-1:0] current_hour;
    logic [HM_W-1:0] current_minute;
    logic            entry_gate_open;
    logic            exit_gate_open;
    logic            entry_denied;

    modport master (
        output entry_req, entry_is_uni, entry_pass,
        output exit_req, exit_is_uni, exit_pass,
        output uni_is_vacated_space, is_vacated_space,
        input  car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
        input  current_hour, current_minute,
        input  entry_gate_open, exit_gate_open, entry_denied
    );

    modport slave (
        input  entry_req, entry_is_uni, entry_pass,
        input  exit_req, exit_is_uni, exit_pass,
        input  uni_is_vacated_space, is_vacated_space,
        output car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
        output current_hour, current_minute,
        output entry_gate_open, exit_gate_open, entry_denied
    );

endinterface

// File: rtl/parking_gate_fsm.sv
// One barrier controller: request -> vacancy check -> open -> pass event.
// Gate opens 2 cycles after req; event 1 cycle after pass (+1 if held).
// hold delays the event pulse while the other gate owns the event slot.
module parking_gate_fsm
    import parking_pkg::*;
#(
    parameter bit CHECK_SPACE  = 1'b1,
    parameter int PASS_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic is_uni,
    input  logic pass,
    input  logic uni_vacant,
    input  logic vacant,
    input  logic hold,
    output logic gate_open,
    output logic evt,
    output logic evt_uni,
    output logic denied
);

    localparam int TW = (PASS_TIMEOUT > 1) ? $clog2(PASS_TIMEOUT) : 1;

    gate_state_t   state;
    logic          cls;
    logic [TW-1:0] tmo;

    // Gate sequencing with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cls       <= 1'b0;
            tmo       <= '0;
            gate_open <= 1'b0;
            evt       <= 1'b0;
            evt_uni   <= 1'b0;
            denied    <= 1'b0;
        end else begin
            evt     <= 1'b0;
            evt_uni <= 1'b0;
            denied  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        cls   <= is_uni;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    // Vacancy is only looked at here; later flag changes are ignored.
                    if (!CHECK_SPACE || (cls ? uni_vacant : vacant)) begin
                        state     <= OPEN;
                        gate_open <= 1'b1;
                        tmo       <= '0;
                    end else begin
                        state  <= DENY;
                        denied <= 1'b1;
                    end
                end
                OPEN: begin
                    if (pass) begin
                        gate_open <= 1'b0;
                        state     <= EMIT;
                        evt       <= !hold;
                        evt_uni   <= !hold && cls;
                    end else if (tmo == TW'(PASS_TIMEOUT - 1)) begin
                        gate_open <= 1'b0;
                        state     <= WAIT_CLEAR;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                EMIT: begin
                    // Stay here until the pulse has actually been issued once.
                    if (evt) begin
                        state <= WAIT_CLEAR;
                    end else if (!hold) begin
                        evt     <= 1'b1;
                        evt_uni <= cls;
                    end
                end
                DENY: begin
                    state <= WAIT_CLEAR;
                end
                WAIT_CLEAR: begin
                    if (!req) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/parking_gate_ctrl.sv
// Entry/exit gate front-end plus time-of-day counter for the occupancy block.
// Gate opens 2 cycles after req; event 1 cycle after pass; clock ticks every cycle group.
// Exit event wins a same-cycle collision; entry event slips one cycle.
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int TICKS_PER_MINUTE = 1,
    parameter int START_HOUR       = 0,
    parameter int PASS_TIMEOUT     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    parking_gate_ctrl_if.slave   ifc
);

    localparam int KW = (TICKS_PER_MINUTE > 1) ? $clog2(TICKS_PER_MINUTE) : 1;

    logic [KW-1:0]   tick;
    logic [HM_W-1:0] hour;
    logic [HM_W-1:0] minute;
    logic            entry_hold;
    logic            entry_deny;
    logic            exit_deny;

    // Time of day: tick -> minute -> hour, wrapping at 23:59.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick   <= '0;
            minute <= '0;
            hour   <= HM_W'(START_HOUR);
        end else if (tick == KW'(TICKS_PER_MINUTE - 1)) begin
            tick <= '0;
            if (minute == HM_W'(MINUTES_PER_HOUR - 1)) begin
                minute <= '0;
                hour   <= (hour == HM_W'(HOURS_PER_DAY - 1)) ? '0 : hour + 1'b1;
            end else begin
                minute <= minute + 1'b1;
            end
        end else begin
            tick <= tick + 1'b1;
        end
    end

    assign ifc.current_hour   = hour;
    assign ifc.current_minute = minute;

    // The exit gate is open exactly while its FSM is in OPEN, so this is
    // "exit will emit next cycle"; the entry pulse is pushed back one cycle.
    assign entry_hold = ifc.exit_gate_open & ifc.exit_pass;

    parking_gate_fsm #(
        .CHECK_SPACE  (1'b1),
        .PASS_TIMEOUT (PASS_TIMEOUT)
    ) u_entry (
        .clk        (clk),
        .rst        (rst),
        .req        (ifc.entry_req),
        .is_uni     (ifc.entry_is_uni),
        .pass       (ifc.entry_pass),
        .uni_vacant (ifc.uni_is_vacated_space),
        .vacant     (ifc.is_vacated_space),
        .hold       (entry_hold),
        .gate_open  (ifc.entry_gate_open),
        .evt        (ifc.car_entered),
        .evt_uni    (ifc.is_uni_car_entered),
        .denied     (entry_deny)
    );

    parking_gate_fsm #(
        .CHECK_SPACE  (1'b0),
        .PASS_TIMEOUT (PASS_TIMEOUT)
    ) u_exit (
        .clk        (clk),
        .rst        (rst),
        .req        (ifc.exit_req),
        .is_uni     (ifc.exit_is_uni),
        .pass       (ifc.exit_pass),
        .uni_vacant (1'b0),
        .vacant     (1'b0),
        .hold       (1'b0),
        .gate_open  (ifc.exit_gate_open),
        .evt        (ifc.car_exited),
        .evt_uni    (ifc.is_uni_car_exited),
        .denied     (exit_deny)
    );

    // Exit never checks space, so its deny flop stays 0; merging is harmless.
    assign ifc.entry_denied = entry_deny | exit_deny;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl: time-of-day, entry/exit sequencing,
// deny, timeout, event collision and mid-operation reset.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_parking_gate_ctrl;
    import parking_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    parking_gate_ctrl_if ifc();

    parking_gate_ctrl #(
        .TICKS_PER_MINUTE (1),
        .START_HOUR       (7),
        .PASS_TIMEOUT     (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ifc (ifc)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int gate_hi;
    int deny_cnt;
    int ent_cnt;

    initial begin
        ifc.entry_req            = 1'b0;
        ifc.entry_is_uni         = 1'b0;
        ifc.entry_pass           = 1'b0;
        ifc.exit_req             = 1'b0;
        ifc.exit_is_uni          = 1'b0;
        ifc.exit_pass            = 1'b0;
        ifc.uni_is_vacated_space = 1'b0;
        ifc.is_vacated_space     = 1'b0;

        // Reset state
        step();
        step();
        rst = 1'b0;
        check("rst_hour", ifc.current_hour, 7);
        check("rst_minute", ifc.current_minute, 0);
        check("rst_entered", ifc.car_entered, 0);
        check("rst_exited", ifc.car_exited, 0);
        check("rst_entry_gate", ifc.entry_gate_open, 0);
        check("rst_exit_gate", ifc.exit_gate_open, 0);
        check("rst_denied", ifc.entry_denied, 0);

        // Time of day: 60 minutes -> 08:00, then 17 hours -> 01:00
        repeat (60) step();
        check("tod_hour_8", ifc.current_hour, 8);
        check("tod_min_8", ifc.current_minute, 0);
        repeat (1020) step();
        check("tod_hour_wrap", ifc.current_hour, 1);
        check("tod_min_wrap", ifc.current_minute, 0);

        // Uni entry with uni space only (non-uni flag 0 proves flag selection)
        ifc.uni_is_vacated_space = 1'b1;
        ifc.is_vacated_space     = 1'b0;
        ifc.entry_is_uni         = 1'b1;
        ifc.entry_req            = 1'b1;
        step();
        check("uni_check_gate", ifc.entry_gate_open, 0);
        ifc.entry_is_uni = 1'b0;
        step();
        check("uni_gate_open", ifc.entry_gate_open, 1);
        step();
        step();
        step();
        check("uni_gate_still", ifc.entry_gate_open, 1);
        check("uni_no_early_evt", ifc.car_entered, 0);
        ifc.entry_pass = 1'b1;
        step();
        ifc.entry_pass = 1'b0;
        check("uni_entered", ifc.car_entered, 1);
        check("uni_class", ifc.is_uni_car_entered, 1);
        check("uni_gate_closed", ifc.entry_gate_open, 0);
        check("uni_no_exit", ifc.car_exited, 0);
        step();
        check("uni_pulse_end", ifc.car_entered, 0);
        check("uni_class_end", ifc.is_uni_car_entered, 0);
        ifc.entry_req = 1'b0;
        step();

        // Non-uni entry with no space: deny once, gate never opens
        ifc.entry_is_uni = 1'b0;
        ifc.entry_req    = 1'b1;
        step();
        check("deny_check", ifc.entry_denied, 0);
        step();
        check("deny_pulse", ifc.entry_denied, 1);
        check("deny_gate", ifc.entry_gate_open, 0);
        step();
        check("deny_one_cycle", ifc.entry_denied, 0);
        deny_cnt = 0;
        gate_hi  = 0;
        ent_cnt  = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (ifc.entry_denied === 1'b1) deny_cnt++;
            if (ifc.entry_gate_open === 1'b1) gate_hi++;
            if (ifc.car_entered === 1'b1) ent_cnt++;
        end
        check("deny_no_repeat", deny_cnt, 0);
        check("deny_gate_never", gate_hi, 0);
        check("deny_no_entered", ent_cnt, 0);
        ifc.entry_req = 1'b0;
        step();

        // Timeout: gate open 16 cycles, no event; vacancy drop while open ignored
        ifc.is_vacated_space = 1'b1;
        ifc.entry_req        = 1'b1;
        step();
        step();
        check("tmo_gate_open", ifc.entry_gate_open, 1);
        gate_hi = 1;
        ent_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 5) ifc.is_vacated_space = 1'b0;
            step();
            if (ifc.entry_gate_open === 1'b1) gate_hi++;
            if (ifc.car_entered === 1'b1) ent_cnt++;
        end
        check("tmo_gate_cycles", gate_hi, 16);
        check("tmo_no_event", ent_cnt, 0);
        ifc.entry_pass = 1'b1;
        step();
        ifc.entry_pass = 1'b0;
        check("tmo_late_pass", ifc.car_entered, 0);
        step();
        check("tmo_late_pass2", ifc.car_entered, 0);
        ifc.entry_req = 1'b0;
        step();

        // Simultaneous pass on both gates: exit first, entry one cycle later
        ifc.is_vacated_space = 1'b1;
        ifc.entry_is_uni     = 1'b0;
        ifc.exit_is_uni      = 1'b1;
        ifc.entry_req        = 1'b1;
        ifc.exit_req         = 1'b1;
        step();
        step();
        check("sim_entry_open", ifc.entry_gate_open, 1);
        check("sim_exit_open", ifc.exit_gate_open, 1);
        ifc.entry_pass = 1'b1;
        ifc.exit_pass  = 1'b1;
        step();
        ifc.entry_pass = 1'b0;
        ifc.exit_pass  = 1'b0;
        check("sim_k_exited", ifc.car_exited, 1);
        check("sim_k_exit_class", ifc.is_uni_car_exited, 1);
        check("sim_k_entered", ifc.car_entered, 0);
        check("sim_k_exit_gate", ifc.exit_gate_open, 0);
        step();
        check("sim_k1_entered", ifc.car_entered, 1);
        check("sim_k1_entry_class", ifc.is_uni_car_entered, 0);
        check("sim_k1_exited", ifc.car_exited, 0);
        check("sim_k1_exit_class", ifc.is_uni_car_exited, 0);
        step();
        check("sim_k2_entered", ifc.car_entered, 0);
        ifc.entry_req = 1'b0;
        ifc.exit_req  = 1'b0;
        step();

        // Exit pass while exit FSM idle is ignored
        ifc.exit_pass = 1'b1;
        step();
        ifc.exit_pass = 1'b0;
        step();
        check("exit_idle_pass", ifc.car_exited, 0);

        // Reset while entry gate open and pass asserted
        ifc.entry_req = 1'b1;
        step();
        step();
        check("rstop_gate_open", ifc.entry_gate_open, 1);
        ifc.entry_pass = 1'b1;
        rst            = 1'b1;
        step();
        rst            = 1'b0;
        ifc.entry_pass = 1'b0;
        ifc.entry_req  = 1'b0;
        check("rstop_no_event", ifc.car_entered, 0);
        check("rstop_gate_closed", ifc.entry_gate_open, 0);
        check("rstop_state_idle", dut.u_entry.state, IDLE);
        check("rstop_hour", ifc.current_hour, 7);
        check("rstop_minute", ifc.current_minute, 0);
        step();
        check("rstop_no_event2", ifc.car_entered, 0);
        check("rstop_minute_run", ifc.current_minute, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
